// File: rtl/nes_bus_pkg.sv
// Shared definitions for the NES CPU bus responder: address map, DMA FSM states,
// region decode and read-return selection.
package nes_bus_pkg;

    localparam logic [15:0] RAM_END   = 16'h1FFF;
    localparam logic [15:0] PPU_BASE  = 16'h2000;
    localparam logic [15:0] PPU_END   = 16'h3FFF;
    localparam logic [15:0] APU_BASE  = 16'h4000;
    localparam logic [15:0] APU_END   = 16'h401F;
    localparam logic [15:0] CART_BASE = 16'h4020;
    localparam logic [15:0] DMA_ADDR  = 16'h4014;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        RD,
        WR
    } dma_state_t;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_PPU,
        REG_DMA,
        REG_OPEN,
        REG_CART
    } region_t;

    function automatic region_t decode_region(input logic [15:0] addr,
                                              input logic [15:0] dma_reg);
        region_t r;
        if (addr <= RAM_END)       r = REG_RAM;
        else if (addr <= PPU_END)  r = REG_PPU;
        else if (addr == dma_reg)  r = REG_DMA;
        else if (addr <= APU_END)  r = REG_OPEN;
        else                       r = REG_CART;
        return r;
    endfunction

    // Anything without a real data source (APU/IO space, reads of the DMA register) floats to open bus.
    function automatic logic [7:0] select_data(input region_t    r,
                                               input logic [7:0] ram_q,
                                               input logic [7:0] ppu_q,
                                               input logic [7:0] cart_q,
                                               input logic [7:0] open_q);
        logic [7:0] d;
        case (r)
            REG_RAM:  d = ram_q;
            REG_PPU:  d = ppu_q;
            REG_CART: d = cart_q;
            default:  d = open_q;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/nes_wram_2k.sv
// NES work RAM: synchronous single-port 2^AW x 8 memory with registered read data.
module nes_wram_2k #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:(1 << AW) - 1];

    // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/nes_cpu_bus_responder.sv
// 6502 bus responder: address decode, 1-cycle read return, open-bus latch and OAM DMA.
// Define NES_DMA_ALIGN_EN to insert an ALIGN cycle after HALT on odd cycle parity.
module nes_cpu_bus_responder
    import nes_bus_pkg::*;
#(
    parameter int          RAM_AW  = 11,
    parameter logic [15:0] DMA_REG = 16'h4014
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_out,
    input  logic [7:0]  cpu_data_out,
    input  logic        ren,
    input  logic        wen,
    output logic [7:0]  cpu_data_in,
    output logic        rdy,
    output logic [2:0]  ppu_reg,
    output logic        ppu_rd,
    output logic        ppu_wr,
    output logic [7:0]  ppu_wdata,
    input  logic [7:0]  ppu_rdata,
    output logic [15:0] cart_addr,
    output logic        cart_rd,
    output logic        cart_wr,
    output logic [7:0]  cart_wdata,
    input  logic [7:0]  cart_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata
);

    dma_state_t  state;
    logic [7:0]  dma_page;
    logic [7:0]  dma_idx;
    logic        parity;
    logic [7:0]  open_bus;
    logic        rd_pend;
    region_t     rd_region;

    logic [15:0] bus_addr;
    region_t     bus_region;
    region_t     dma_region;
    logic        dma_rd;
    logic        cpu_wr_ok;
    logic        cpu_rd_ok;
    logic        ram_we;
    logic [7:0]  ram_q;
    logic [7:0]  rd_data;

    // The core still completes writes while rdy is low, so HALT accepts them.
    assign cpu_wr_ok = !rst && wen && (rdy || state == HALT);
    assign cpu_rd_ok = !rst && ren && !wen && rdy;
    assign dma_rd    = !rst && state == RD;

    assign bus_addr   = (state == RD) ? {dma_page, dma_idx} : cpu_addr_out;
    assign bus_region = decode_region(bus_addr, DMA_REG);
    assign dma_region = decode_region({dma_page, dma_idx}, DMA_REG);

    assign ram_we  = cpu_wr_ok && bus_region == REG_RAM;
    assign ppu_rd  = (cpu_rd_ok || dma_rd) && bus_region == REG_PPU;
    assign ppu_wr  = cpu_wr_ok && bus_region == REG_PPU;
    assign cart_rd = (cpu_rd_ok || dma_rd) && bus_region == REG_CART;
    assign cart_wr = cpu_wr_ok && bus_region == REG_CART;

    assign ppu_reg    = bus_addr[2:0];
    assign ppu_wdata  = cpu_data_out;
    assign cart_addr  = bus_addr;
    assign cart_wdata = cpu_data_out;

    assign rd_data   = select_data(rd_region, ram_q, ppu_rdata, cart_rdata, open_bus);
    assign oam_we    = state == WR;
    assign oam_addr  = dma_idx;
    assign oam_wdata = select_data(dma_region, ram_q, ppu_rdata, cart_rdata, open_bus);

    nes_wram_2k #(.AW(RAM_AW)) u_wram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (bus_addr[RAM_AW-1:0]),
        .wdata (cpu_data_out),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rdy         <= 1'b1;
            dma_page    <= 8'h00;
            dma_idx     <= 8'h00;
            parity      <= 1'b0;
            open_bus    <= 8'h00;
            cpu_data_in <= 8'h00;
            rd_pend     <= 1'b0;
            rd_region   <= REG_OPEN;
        end else begin
            parity    <= ~parity;
            rd_pend   <= cpu_rd_ok;
            rd_region <= bus_region;

            if (rd_pend) begin
                cpu_data_in <= rd_data;
                open_bus    <= rd_data;
            end
            // A CPU write is the more recent bus value, so it overrides a completing read.
            if (cpu_wr_ok) open_bus <= cpu_data_out;

            case (state)
                IDLE: begin
                    if (cpu_wr_ok && bus_region == REG_DMA) begin
                        dma_page <= cpu_data_out;
                        state    <= HALT;
                        rdy      <= 1'b0;
                    end
                end
                HALT: begin
                    if (!wen) begin
`ifdef NES_DMA_ALIGN_EN
                        state <= parity ? ALIGN : RD;
`else
                        state <= RD;
`endif
                    end
                end
                ALIGN: state <= RD;
                RD:    state <= WR;
                WR: begin
                    dma_idx <= dma_idx + 8'd1;
                    if (dma_idx == 8'hFF) begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                    end else begin
                        state <= RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nes_cpu_bus_responder.sv
// Directed self-checking bench for nes_cpu_bus_responder (RAM mirror, PPU, cart, open bus, OAM DMA).
module tb_nes_cpu_bus_responder;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr_out;
    logic [7:0]  cpu_data_out;
    logic        ren;
    logic        wen;
    logic [7:0]  cpu_data_in;
    logic        rdy;
    logic [2:0]  ppu_reg;
    logic        ppu_rd;
    logic        ppu_wr;
    logic [7:0]  ppu_wdata;
    logic [7:0]  ppu_rdata;
    logic [15:0] cart_addr;
    logic        cart_rd;
    logic        cart_wr;
    logic [7:0]  cart_wdata;
    logic [7:0]  cart_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;

    int errors;
    int checks;
    int cyc;

`ifdef NES_DMA_ALIGN_EN
    localparam int ALIGN_ON = 1;
`else
    localparam int ALIGN_ON = 0;
`endif

    nes_cpu_bus_responder dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr_out (cpu_addr_out),
        .cpu_data_out (cpu_data_out),
        .ren          (ren),
        .wen          (wen),
        .cpu_data_in  (cpu_data_in),
        .rdy          (rdy),
        .ppu_reg      (ppu_reg),
        .ppu_rd       (ppu_rd),
        .ppu_wr       (ppu_wr),
        .ppu_wdata    (ppu_wdata),
        .ppu_rdata    (ppu_rdata),
        .cart_addr    (cart_addr),
        .cart_rd      (cart_rd),
        .cart_wr      (cart_wr),
        .cart_wdata   (cart_wdata),
        .cart_rdata   (cart_rdata),
        .oam_we       (oam_we),
        .oam_addr     (oam_addr),
        .oam_wdata    (oam_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since the last reset edge; bit 0 is the expected cycle parity.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        wen = 1'b1; cpu_addr_out = a; cpu_data_out = d;
        tick;
        wen = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        ren = 1'b1; cpu_addr_out = a;
        tick;
        ren = 1'b0;
        tick;
        d = cpu_data_in;
    endtask

    task automatic test_reset;
        rst = 1'b1; wen = 1'b1; cpu_addr_out = 16'h2000; cpu_data_out = 8'h11;
        @(negedge clk);
        checks++;
        if (ppu_wr !== 1'b0) begin errors++; $display("FAIL reset_ppu_wr: got %b want 0", ppu_wr); end
        tick;
        wen = 1'b0;
        tick;
        rst = 1'b0;
        checks++;
        if (cpu_data_in !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", cpu_data_in); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", rdy); end
        checks++;
        if (oam_we !== 1'b0 || oam_addr !== 8'h00) begin
            errors++; $display("FAIL reset_oam: got we=%b addr=%h want 0/00", oam_we, oam_addr);
        end
        checks++;
        if (ppu_rd !== 1'b0 || cart_rd !== 1'b0 || cart_wr !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: got %b%b%b want 000", ppu_rd, cart_rd, cart_wr);
        end
    endtask

    task automatic test_ram_mirror;
        logic [7:0] d;
        cpu_write(16'h0001, 8'h5A);
        cpu_write(16'h07FF, 8'hC3);
        ren = 1'b1; cpu_addr_out = 16'h0801;
        tick;
        ren = 1'b0;
        checks++;
        if (cpu_data_in !== 8'h00) begin errors++; $display("FAIL ram_latency_hold: got %h want 00", cpu_data_in); end
        tick;
        checks++;
        if (cpu_data_in !== 8'h5A) begin errors++; $display("FAIL ram_0801: got %h want 5a", cpu_data_in); end
        tick;
        checks++;
        if (cpu_data_in !== 8'h5A) begin errors++; $display("FAIL ram_hold: got %h want 5a", cpu_data_in); end
        cpu_read(16'h1801, d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL ram_1801: got %h want 5a", d); end
        cpu_read(16'h17FF, d);
        checks++;
        if (d !== 8'hC3) begin errors++; $display("FAIL ram_17ff: got %h want c3", d); end
    endtask

    task automatic test_ppu;
        logic [7:0] d;
        wen = 1'b1; cpu_addr_out = 16'h3FF9; cpu_data_out = 8'h33;
        @(negedge clk);
        checks++;
        if (ppu_wr !== 1'b1 || ppu_reg !== 3'd1 || ppu_wdata !== 8'h33) begin
            errors++; $display("FAIL ppu_write: got wr=%b reg=%0d data=%h want 1/1/33", ppu_wr, ppu_reg, ppu_wdata);
        end
        tick;
        wen = 1'b0;
        @(negedge clk);
        checks++;
        if (ppu_wr !== 1'b0) begin errors++; $display("FAIL ppu_wr_pulse: got %b want 0", ppu_wr); end
        tick;
        ppu_rdata = 8'hA7;
        ren = 1'b1; cpu_addr_out = 16'h2002;
        @(negedge clk);
        checks++;
        if (ppu_rd !== 1'b1 || ppu_reg !== 3'd2) begin
            errors++; $display("FAIL ppu_rd_strobe: got rd=%b reg=%0d want 1/2", ppu_rd, ppu_reg);
        end
        tick;
        ren = 1'b0;
        tick;
        d = cpu_data_in;
        checks++;
        if (d !== 8'hA7) begin errors++; $display("FAIL ppu_read: got %h want a7", d); end
    endtask

    task automatic test_cart;
        logic [7:0] d;
        wen = 1'b1; cpu_addr_out = 16'h8123; cpu_data_out = 8'h44;
        @(negedge clk);
        checks++;
        if (cart_wr !== 1'b1 || cart_addr !== 16'h8123 || cart_wdata !== 8'h44) begin
            errors++; $display("FAIL cart_write: got wr=%b addr=%h data=%h want 1/8123/44", cart_wr, cart_addr, cart_wdata);
        end
        tick;
        cpu_addr_out = 16'h4020;
        @(negedge clk);
        checks++;
        if (cart_wr !== 1'b1) begin errors++; $display("FAIL cart_4020: got %b want 1", cart_wr); end
        tick;
        cpu_addr_out = 16'h401F;
        @(negedge clk);
        checks++;
        if (cart_wr !== 1'b0 || ppu_wr !== 1'b0) begin
            errors++; $display("FAIL unmapped_401f_wr: got cart=%b ppu=%b want 0/0", cart_wr, ppu_wr);
        end
        tick;
        wen = 1'b0;
        cart_rdata = 8'h9E;
        cpu_read(16'hC000, d);
        checks++;
        if (d !== 8'h9E) begin errors++; $display("FAIL cart_read: got %h want 9e", d); end
    endtask

    task automatic test_open_bus;
        logic [7:0] d;
        cpu_read(16'h0001, d);
        cpu_read(16'h4018, d);
        checks++;
        if (d !== 8'h5A) begin errors++; $display("FAIL open_bus_read: got %h want 5a", d); end
        cpu_write(16'h0005, 8'hE1);
        cpu_read(16'h401F, d);
        checks++;
        if (d !== 8'hE1) begin errors++; $display("FAIL open_bus_write: got %h want e1", d); end
        cpu_read(16'h4014, d);
        checks++;
        if (d !== 8'hE1) begin errors++; $display("FAIL open_bus_dma_reg: got %h want e1", d); end
    endtask

    task automatic test_rw_conflict;
        logic [7:0] d;
        ren = 1'b1; wen = 1'b1; cpu_addr_out = 16'h0010; cpu_data_out = 8'h77;
        tick;
        ren = 1'b0; wen = 1'b0;
        tick;
        checks++;
        if (cpu_data_in !== 8'hE1) begin errors++; $display("FAIL rw_conflict_no_read: got %h want e1", cpu_data_in); end
        cpu_read(16'h0010, d);
        checks++;
        if (d !== 8'h77) begin errors++; $display("FAIL rw_conflict_write: got %h want 77", d); end
    endtask

    // Trigger a DMA from page pg; ext holds a CPU write during the first HALT cycle.
    // mode 0: source byte equals its index; mode 1: source is cart returning 8'h3C.
    task automatic dma_run(input logic [7:0] pg, input bit ext, input int mode, input string name);
        int  low;
        int  pulses;
        int  cart_pulses;
        int  exp_low;
        bit  p0;
        logic [7:0] exp_d;
        low = 0; pulses = 0; cart_pulses = 0; p0 = 1'b0;
        wen = 1'b1; cpu_addr_out = 16'h4014; cpu_data_out = pg;
        tick;
        if (ext) begin cpu_addr_out = 16'h0300; cpu_data_out = 8'hAB; end
        else wen = 1'b0;
        for (int n = 0; n < 1200; n++) begin
            @(negedge clk);
            if (rdy === 1'b0) begin
                if (low == 0) p0 = cyc[0];
                low++;
                if (cart_rd === 1'b1) cart_pulses++;
                if (oam_we === 1'b1) begin
                    exp_d = (mode == 0) ? pulses[7:0] : 8'h3C;
                    checks++;
                    if (oam_addr !== pulses[7:0] || oam_wdata !== exp_d) begin
                        errors++;
                        $display("FAIL %s_oam_byte: got addr=%h data=%h want %h/%h", name, oam_addr, oam_wdata, pulses[7:0], exp_d);
                    end
                    pulses++;
                end
            end else if (low > 0) begin
                break;
            end
            @(posedge clk);
            #1;
            wen = 1'b0;
        end
        tick;
        exp_low = 513 + (ext ? 1 : 0) + ((ALIGN_ON != 0 && (p0 ^ ext)) ? 1 : 0);
        checks++;
        if (low != exp_low) begin errors++; $display("FAIL %s_rdy_low: got %0d want %0d", name, low, exp_low); end
        checks++;
        if (pulses != 256) begin errors++; $display("FAIL %s_oam_pulses: got %0d want 256", name, pulses); end
        checks++;
        if (cart_pulses != ((mode == 1) ? 256 : 0)) begin
            errors++; $display("FAIL %s_cart_rd: got %0d want %0d", name, cart_pulses, (mode == 1) ? 256 : 0);
        end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL %s_rdy_end: got %b want 1", name, rdy); end
    endtask

    task automatic test_dma_ram;
        wen = 1'b1;
        for (int i = 0; i < 256; i++) begin
            cpu_addr_out = 16'h0200 + 16'(i);
            cpu_data_out = 8'(i);
            tick;
        end
        wen = 1'b0;
        dma_run(8'h02, 1'b0, 0, "dma_ram");
    endtask

    task automatic test_dma_cart;
        cart_rdata = 8'h3C;
        dma_run(8'h60, 1'b0, 1, "dma_cart");
    endtask

    task automatic test_halt_ext;
        logic [7:0] d;
        dma_run(8'h02, 1'b1, 0, "halt_ext");
        cpu_read(16'h0300, d);
        checks++;
        if (d !== 8'hAB) begin errors++; $display("FAIL halt_ext_write: got %h want ab", d); end
    endtask

    task automatic test_dma_reset;
        bit found;
        int extra;
        found = 1'b0; extra = 0;
        cpu_write(16'h4014, 8'h02);
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk);
            if (oam_we === 1'b1 && oam_addr === 8'd100) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL dma_reset_reach: got none want byte 100"); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (rdy !== 1'b1 || oam_we !== 1'b0) begin
            errors++; $display("FAIL dma_reset_state: got rdy=%b we=%b want 1/0", rdy, oam_we);
        end
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (oam_we !== 1'b0 || rdy !== 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL dma_reset_quiet: got %0d active cycles want 0", extra); end
        tick;
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; ren = 1'b0; wen = 1'b0;
        cpu_addr_out = 16'h0000; cpu_data_out = 8'h00;
        ppu_rdata = 8'h00; cart_rdata = 8'h00;
        test_reset;
        test_ram_mirror;
        test_ppu;
        test_cart;
        test_open_bus;
        test_rw_conflict;
        test_dma_ram;
        test_dma_cart;
        test_halt_ext;
        test_dma_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
